// File: rtl/nanorv32_prog_loader_pkg.sv
// rtl/nanorv32_prog_loader_pkg.sv - loader state encodings and shared constants
package nanorv32_prog_loader_pkg;

    localparam int LDR_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        NANORV32_LDR_IDLE    = 3'd0,
        NANORV32_LDR_COLLECT = 3'd1,
        NANORV32_LDR_WRITE   = 3'd2,
        NANORV32_LDR_DONE    = 3'd3,
        NANORV32_LDR_ERROR   = 3'd4
    } ldr_state_t;

endpackage

// File: rtl/nanorv32_prog_loader_if.sv
// rtl/nanorv32_prog_loader_if.sv - byte-stream input and code-memory write bus of the loader
interface nanorv32_prog_loader_if #(
    parameter int ROM_ADDRESS_SIZE = 15
);
    logic                        ld_byte_valid;
    logic [7:0]                  ld_byte_data;
    logic                        ld_byte_last;
    logic                        ld_byte_ready;
    logic                        loader_mem_wr;
    logic [ROM_ADDRESS_SIZE-3:0] loader_mem_addr;
    logic [31:0]                 loader_mem_wdata;
    logic                        mem_loader_ready;

    // master: byte source plus code memory; slave: the loader itself
    modport master (
        output ld_byte_valid, ld_byte_data, ld_byte_last, mem_loader_ready,
        input  ld_byte_ready, loader_mem_wr, loader_mem_addr, loader_mem_wdata
    );

    modport slave (
        input  ld_byte_valid, ld_byte_data, ld_byte_last, mem_loader_ready,
        output ld_byte_ready, loader_mem_wr, loader_mem_addr, loader_mem_wdata
    );
endinterface

// File: rtl/nanorv32_byte_packer.sv
// rtl/nanorv32_byte_packer.sv - little-endian byte-to-word packer with zero-pad on clear
module nanorv32_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [1:0]  idx,
    output logic [31:0] word
);
    logic [1:0]  idx_q;
    logic [31:0] word_q;

    // Clearing to zero is what pads a short final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            word_q <= 32'h0;
        end else if (clear) begin
            idx_q  <= 2'd0;
            word_q <= 32'h0;
        end else if (byte_en) begin
            word_q[{idx_q, 3'b000} +: 8] <= byte_data;
            idx_q                        <= idx_q + 2'd1;
        end
    end

    assign idx  = idx_q;
    assign word = word_q;
endmodule

// File: rtl/nanorv32_prog_loader.sv
// rtl/nanorv32_prog_loader.sv - byte-stream code-memory loader holding the CPU in reset
// Optional image checksum check: NANORV32_LOADER_CHECKSUM_EN
module nanorv32_prog_loader
    import nanorv32_prog_loader_pkg::*;
#(
    parameter int ROM_ADDRESS_SIZE = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld_start,
`ifdef NANORV32_LOADER_CHECKSUM_EN
    input  logic [31:0]            ld_expected_sum,
`endif
    nanorv32_prog_loader_if.slave  bus,
    output logic                   cpu_rst_n,
    output logic                   ld_done,
    output logic                   ld_error
);
    localparam int AW = ROM_ADDRESS_SIZE - 2;
    localparam int CW = ROM_ADDRESS_SIZE - 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** AW);

    ldr_state_t    state_q, state_d;
    logic [CW-1:0] word_cnt_q;
    logic          last_q;
    logic          start_go, byte_fire, word_end, mem_fire, pk_clear, sum_ok;
    logic [1:0]    pk_idx;
    logic [31:0]   pk_word;

    nanorv32_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pk_clear),
        .byte_en   (byte_fire),
        .byte_data (bus.ld_byte_data),
        .idx       (pk_idx),
        .word      (pk_word)
    );

    always_comb begin
        state_d   = state_q;
        start_go  = 1'b0;
        byte_fire = 1'b0;
        word_end  = 1'b0;
        mem_fire  = 1'b0;
        pk_clear  = 1'b0;
        case (state_q)
            NANORV32_LDR_IDLE, NANORV32_LDR_DONE, NANORV32_LDR_ERROR: begin
                if (ld_start) begin
                    start_go = 1'b1;
                    pk_clear = 1'b1;
                    state_d  = NANORV32_LDR_COLLECT;
                end
            end
            NANORV32_LDR_COLLECT: begin
                byte_fire = bus.ld_byte_valid;
                word_end  = byte_fire && (pk_idx == 2'd3 || bus.ld_byte_last);
                // A word completing with the memory already full is an overflow, never written.
                if (word_end)
                    state_d = (word_cnt_q == DEPTH) ? NANORV32_LDR_ERROR : NANORV32_LDR_WRITE;
            end
            NANORV32_LDR_WRITE: begin
                mem_fire = bus.mem_loader_ready;
                if (mem_fire) begin
                    pk_clear = 1'b1;
                    if (!last_q)
                        state_d = NANORV32_LDR_COLLECT;
                    else
                        state_d = sum_ok ? NANORV32_LDR_DONE : NANORV32_LDR_ERROR;
                end
            end
            default: state_d = NANORV32_LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NANORV32_LDR_IDLE;
            word_cnt_q <= '0;
            last_q     <= 1'b0;
            cpu_rst_n  <= 1'b0;
            ld_done    <= 1'b0;
            ld_error   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_go) begin
                word_cnt_q <= '0;
                last_q     <= 1'b0;
            end else begin
                if (mem_fire)
                    word_cnt_q <= word_cnt_q + CW'(1);
                if (word_end)
                    last_q <= bus.ld_byte_last;
            end
            // Status flags follow the next state so they are valid in the first cycle of DONE/ERROR.
            cpu_rst_n <= (state_d == NANORV32_LDR_DONE);
            ld_done   <= (state_d == NANORV32_LDR_DONE);
            ld_error  <= (state_d == NANORV32_LDR_ERROR);
        end
    end

`ifdef NANORV32_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, expected_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= 32'h0;
            expected_q <= 32'h0;
        end else if (start_go) begin
            sum_q      <= 32'h0;
            expected_q <= ld_expected_sum;
        end else if (mem_fire) begin
            sum_q <= sum_q + pk_word;
        end
    end

    assign sum_ok = ((sum_q + pk_word) == expected_q);
`else
    assign sum_ok = 1'b1;
`endif

    assign bus.ld_byte_ready    = (state_q == NANORV32_LDR_COLLECT);
    assign bus.loader_mem_wr    = (state_q == NANORV32_LDR_WRITE);
    assign bus.loader_mem_addr  = word_cnt_q[AW-1:0];
    assign bus.loader_mem_wdata = pk_word;
endmodule

// File: tb/tb_nanorv32_prog_loader.sv
// tb/tb_nanorv32_prog_loader.sv - self-checking bench for nanorv32_prog_loader
module tb_nanorv32_prog_loader;
    localparam int RAS   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ld_start = 1'b0;
    logic cpu_rst_n, ld_done, ld_error;
`ifdef NANORV32_LOADER_CHECKSUM_EN
    logic [31:0] ld_expected_sum = 32'h0;
`endif

    int checks = 0;
    int errors = 0;
    int rmode = 0;
    bit man_ready = 1'b1;
    int gap_max = 0;

    logic [7:0]  stim_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    nanorv32_prog_loader_if #(.ROM_ADDRESS_SIZE(RAS)) bus();

    nanorv32_prog_loader #(.ROM_ADDRESS_SIZE(RAS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ld_start        (ld_start),
`ifdef NANORV32_LOADER_CHECKSUM_EN
        .ld_expected_sum (ld_expected_sum),
`endif
        .bus             (bus),
        .cpu_rst_n       (cpu_rst_n),
        .ld_done         (ld_done),
        .ld_error        (ld_error)
    );

    always #5 clk = ~clk;

    // memory acceptance: 0 always ready, 1 random stalls, 2 follows man_ready
    initial begin
        bus.mem_loader_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rmode)
                0:       bus.mem_loader_ready = 1'b1;
                1:       bus.mem_loader_ready = ($urandom_range(0, 2) != 0);
                default: bus.mem_loader_ready = man_ready;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.loader_mem_wr && bus.mem_loader_ready) begin
            wa_q.push_back(32'(bus.loader_mem_addr));
            wd_q.push_back(bus.loader_mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit l);
        int t;
        t = 0;
        if (gap_max > 0)
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        @(negedge clk);
        while (!bus.ld_byte_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("byte_ready_timeout", 32'(t < 200), 32'd1);
        bus.ld_byte_valid = 1'b1;
        bus.ld_byte_data  = d;
        bus.ld_byte_last  = l;
        @(negedge clk);
        bus.ld_byte_valid = 1'b0;
        bus.ld_byte_last  = 1'b0;
        bus.ld_byte_data  = 8'h00;
    endtask

    task automatic run_load(input string tag, input logic [31:0] exp_sum, input int mode);
        int n, nwords, nwr, t;
        bit exp_err;
        logic [31:0] mw[$];
        logic [31:0] sum;
        n      = stim_q.size();
        nwords = (n + 3) / 4;
        mw     = {};
        for (int i = 0; i < nwords; i++) mw.push_back(32'h0);
        for (int i = 0; i < n; i++) mw[i/4] = mw[i/4] | (32'(stim_q[i]) << (8 * (i % 4)));
        exp_err = (nwords > DEPTH);
        nwr     = exp_err ? DEPTH : nwords;
        sum     = 32'h0;
        for (int i = 0; i < nwr; i++) sum = sum + mw[i];
`ifdef NANORV32_LOADER_CHECKSUM_EN
        if (!exp_err && sum != exp_sum) exp_err = 1'b1;
        ld_expected_sum = exp_sum;
`endif
        rmode = mode;
        wa_q.delete();
        wd_q.delete();
        start_load();
        check({tag, "_start_done"},  32'(ld_done),   32'd0);
        check({tag, "_start_err"},   32'(ld_error),  32'd0);
        check({tag, "_start_cpu"},   32'(cpu_rst_n), 32'd0);
        check({tag, "_start_addr"},  32'(bus.loader_mem_addr), 32'd0);
        check({tag, "_start_ready"}, 32'(bus.ld_byte_ready),   32'd1);
        for (int i = 0; i < n; i++) send_byte(stim_q[i], (i == n - 1));
        t = 0;
        while (!(ld_done || ld_error) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_finish_timeout"}, 32'(t < 1000), 32'd1);
        check({tag, "_done"},    32'(ld_done),   32'(!exp_err));
        check({tag, "_error"},   32'(ld_error),  32'(exp_err));
        check({tag, "_cpu"},     32'(cpu_rst_n), 32'(!exp_err));
        check({tag, "_idle_rd"}, 32'(bus.ld_byte_ready), 32'd0);
        check({tag, "_idle_wr"}, 32'(bus.loader_mem_wr), 32'd0);
        check({tag, "_nwr"},     32'(wd_q.size()), 32'(nwr));
        for (int i = 0; i < nwr && i < wd_q.size(); i++) begin
            check({tag, "_addr"}, wa_q[i], 32'(i));
            check({tag, "_data"}, wd_q[i], mw[i]);
        end
        rmode = 0;
    endtask

    initial begin
        logic [31:0] s;
        bus.ld_byte_valid = 1'b0;
        bus.ld_byte_data  = 8'h00;
        bus.ld_byte_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ld_byte_ready), 32'd0);
        check("rst_wr",    32'(bus.loader_mem_wr), 32'd0);
        check("rst_addr",  32'(bus.loader_mem_addr), 32'd0);
        check("rst_wdata", bus.loader_mem_wdata, 32'd0);
        check("rst_cpu",   32'(cpu_rst_n), 32'd0);
        check("rst_done",  32'(ld_done),   32'd0);
        check("rst_err",   32'(ld_error),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        run_load("t1", 32'h0000_0082, 0);
        check("t1_w0_const", wd_q[0], 32'h0000_0013);
        check("t1_w1_const", wd_q[1], 32'h0000_006F);

        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_load("t2", 32'h0403_0806, 0);
        check("t2_w0_const", wd_q[0], 32'h0403_0201);
        check("t2_w1_const", wd_q[1], 32'h0000_0605);

        // stalled write: wr/addr/wdata held while memory is not ready
        rmode = 2;
        man_ready = 1'b0;
`ifdef NANORV32_LOADER_CHECKSUM_EN
        ld_expected_sum = 32'hDDCC_BBAA;
`endif
        start_load();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("t3_wr",    32'(bus.loader_mem_wr),   32'd1);
            check("t3_addr",  32'(bus.loader_mem_addr), 32'd0);
            check("t3_wdata", bus.loader_mem_wdata,     32'hDDCC_BBAA);
            check("t3_ready", 32'(bus.ld_byte_ready),   32'd0);
            @(negedge clk);
        end
        man_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_done", 32'(ld_done), 32'd1);
        rmode = 0;

        stim_q = {};
        for (int i = 0; i < 20; i++) stim_q.push_back(8'(i + 1));
        run_load("t4_ovf", 32'h0, 0);
        stim_q = {};
        for (int i = 0; i < 16; i++) stim_q.push_back(8'(8'hA0 + i));
        s = 32'hA3A2A1A0 + 32'hA7A6A5A4 + 32'hABAAA9A8 + 32'hAFAEADAC;
        run_load("t4_full", s, 0);

        // async reset in the middle of a word
        start_load();
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_ready", 32'(bus.ld_byte_ready), 32'd0);
        check("t5_wr",    32'(bus.loader_mem_wr), 32'd0);
        check("t5_addr",  32'(bus.loader_mem_addr), 32'd0);
        check("t5_wdata", bus.loader_mem_wdata, 32'd0);
        check("t5_cpu",   32'(cpu_rst_n), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load("t5_reload", 32'h4433_2211, 0);
        check("t5_w0_const", wd_q[0], 32'h4433_2211);

`ifdef NANORV32_LOADER_CHECKSUM_EN
        stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_load("t6_match", 32'h3, 0);
        check("t6_match_done", 32'(ld_done), 32'd1);
        run_load("t6_mismatch", 32'h4, 0);
        check("t6_mismatch_err", 32'(ld_error), 32'd1);
        run_load("t6_recover", 32'h3, 0);
`endif

        for (int it = 0; it < 14; it++) begin
            int n;
            n = $urandom_range(1, 20);
            stim_q = {};
            for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
            s = 32'h0;
            for (int i = 0; i < n && i < 16; i++) s = s + (32'(stim_q[i]) << (8 * (i % 4)));
            if ($urandom_range(0, 3) == 0) s = s + 32'd1;
            gap_max = $urandom_range(0, 2);
            run_load("rand", s, $urandom_range(0, 1));
        end
        gap_max = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
